// File: rtl/mult_div_pkg.sv
// Shared types for the iterative multiply/divide unit: FSM states, op encoding,
// iteration counter sizing.
package mult_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_div_if.sv
// Request/result bundle between the CPU control path and the multiply/divide unit.
// master drives operands and start; slave returns hi/lo and status.
interface mult_div_if #(parameter int WIDTH = 32);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (output start, op, a, b,
                  input  hi, lo, busy, done, div_zero);
  modport slave  (input  start, op, a, b,
                  output hi, lo, busy, done, div_zero);
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration on magnitudes: shift in the next dividend bit,
// trial-subtract the divisor, emit one quotient bit. Purely combinational.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic           fits;

  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    fits    = (shifted >= {1'b0, dvsr});
    // rem_in < dvsr keeps the partial remainder within WIDTH bits after subtraction
    rem_out = fits ? (shifted[WIDTH-1:0] - dvsr) : shifted[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed mult (radix-2 Booth) / div (restoring); WIDTH+1 cycle latency,
// one op in flight, start ignored unless idle; all outputs registered.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset_n,
  mult_div_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("mult_div_unit: WIDTH must be even and >= 4");
  end

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic              last;
  logic              op_r, b_zero, neg_q, neg_r;
  logic [2*WIDTH:0]  acc;
  logic [WIDTH-1:0]  mcand, rem, quo, rem_nxt, quo_nxt;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic [WIDTH:0]    a_ext, m_ext, booth_sum;

  assign last  = (cnt == CW'(WIDTH - 1));
  assign a_mag = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign b_mag = bus.b[WIDTH-1] ? -bus.b : bus.b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.start) state_nxt = ST_RUN;
      ST_RUN:  if (last)      state_nxt = ST_FIN;
      ST_FIN:                 state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // Booth add/sub is done one bit wider so a most-negative multiplicand cannot overflow
  always_comb begin
    a_ext = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
    m_ext = {mcand[WIDTH-1], mcand};
    case (acc[1:0])
      2'b01:   booth_sum = a_ext + m_ext;
      2'b10:   booth_sum = a_ext - m_ext;
      default: booth_sum = a_ext;
    endcase
  end

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (rem),
    .quo_in  (quo),
    .dvsr    (mcand),
    .rem_out (rem_nxt),
    .quo_out (quo_nxt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt          <= '0;
      op_r         <= OP_MULT;
      b_zero       <= 1'b0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      acc          <= '0;
      mcand        <= '0;
      rem          <= '0;
      quo          <= '0;
      bus.hi       <= '0;
      bus.lo       <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.div_zero <= 1'b0;
    end else begin
      bus.busy     <= (state != ST_IDLE);
      bus.done     <= (state == ST_FIN);
      bus.div_zero <= (state == ST_FIN) && (op_r == OP_DIV) && b_zero;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            op_r   <= bus.op;
            cnt    <= '0;
            b_zero <= (bus.b == '0);
            neg_q  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            neg_r  <= bus.a[WIDTH-1];
            acc    <= {{WIDTH{1'b0}}, bus.b, 1'b0};
            mcand  <= (bus.op == OP_DIV) ? b_mag : bus.a;
            rem    <= '0;
            quo    <= a_mag;
          end
        end
        ST_RUN: begin
          cnt <= cnt + 1'b1;
          if (op_r == OP_MULT) begin
            acc <= {booth_sum, acc[WIDTH:1]};
          end else begin
            rem <= rem_nxt;
            quo <= quo_nxt;
          end
        end
        ST_FIN: begin
          if (op_r == OP_MULT) begin
            bus.hi <= acc[2*WIDTH:WIDTH+1];
            bus.lo <= acc[WIDTH:1];
          end else if (!b_zero) begin
            bus.lo <= neg_q ? -quo : quo;
            bus.hi <= neg_r ? -rem : rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed plus randomized bench for mult_div_unit, checked cycle by cycle against
// an arithmetic reference model (64-bit products, truncating division).
module tb_mult_div_unit;

  localparam int W = 32;

  logic clk;
  logic reset_n;
  int   n_assert;
  int   n_fail;
  logic [W-1:0] exp_hi, exp_lo;

  mult_div_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: exact signed product; C-style truncating quotient/remainder
  task automatic model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] nh, output logic [W-1:0] nl, output logic dz);
    longint sa, sb, p, q, r;
    sa = $signed(a);
    sb = $signed(b);
    dz = 1'b0;
    nh = exp_hi;
    nl = exp_lo;
    if (op == 1'b0) begin
      p  = sa * sb;
      nh = p[63:32];
      nl = p[31:0];
    end else if (b == '0) begin
      dz = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      nl = q[31:0];
      nh = r[31:0];
    end
  endtask

  task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int repulse_k, input int reset_k);
    logic [W-1:0] nh, nl;
    logic         dz;
    model(op, a, b, nh, nl, dz);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.op    = 1'($urandom_range(0, 1));
    check("busy k=0", W'(bus.busy), '0);
    check("done k=0", W'(bus.done), '0);
    for (int k = 1; k <= W + 1; k++) begin
      @(posedge clk); #1;
      check($sformatf("busy k=%0d", k), W'(bus.busy), W'(1));
      check($sformatf("done k=%0d", k), W'(bus.done), W'(k == W + 1));
      check($sformatf("div_zero k=%0d", k), W'(bus.div_zero), W'((k == W + 1) && dz));
      check($sformatf("hi k=%0d", k), bus.hi, (k == W + 1) ? nh : exp_hi);
      check($sformatf("lo k=%0d", k), bus.lo, (k == W + 1) ? nl : exp_lo);
      bus.start = (k == repulse_k);
      if (k == repulse_k) begin
        bus.op = 1'b0;
        bus.a  = 32'd9;
        bus.b  = 32'd9;
      end
      if (k == reset_k) begin
        reset_n = 1'b0;
        #1;
        exp_hi = '0;
        exp_lo = '0;
        check("reset busy", W'(bus.busy), '0);
        check("reset done", W'(bus.done), '0);
        check("reset hi", bus.hi, '0);
        check("reset lo", bus.lo, '0);
        repeat (2) @(posedge clk);
        #1;
        check("reset hold done", W'(bus.done), '0);
        reset_n = 1'b1;
        return;
      end
    end
    exp_hi = nh;
    exp_lo = nl;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("idle busy", W'(bus.busy), '0);
      check("idle done", W'(bus.done), '0);
      check("idle hi", bus.hi, exp_hi);
      check("idle lo", bus.lo, exp_lo);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rop;
    n_assert  = 0;
    n_fail    = 0;
    exp_hi    = '0;
    exp_lo    = '0;
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst hi", bus.hi, '0);
    check("rst lo", bus.lo, '0);
    check("rst busy", W'(bus.busy), '0);
    check("rst done", W'(bus.done), '0);
    check("rst div_zero", W'(bus.div_zero), '0);
    reset_n = 1'b1;
    idle_cycles(2);

    run_op(1'b0, 32'd2, 32'd4, -1, -1);
    check("mul 2x4 lo", bus.lo, 32'd8);
    check("mul 2x4 hi", bus.hi, 32'd0);
    idle_cycles(1);
    run_op(1'b0, 32'hFFFF_FFFD, 32'd5, -1, -1);
    check("mul -3x5 hi", bus.hi, 32'hFFFF_FFFF);
    check("mul -3x5 lo", bus.lo, 32'hFFFF_FFF1);
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, -1, -1);
    check("mul min2 hi", bus.hi, 32'h4000_0000);
    check("mul min2 lo", bus.lo, 32'h0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, -1, -1);
    check("div -7/2 lo", bus.lo, 32'hFFFF_FFFD);
    check("div -7/2 hi", bus.hi, 32'hFFFF_FFFF);
    run_op(1'b1, 32'd4, 32'd2, -1, -1);
    check("div 4/2 lo", bus.lo, 32'd2);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    check("div min/-1 lo", bus.lo, 32'h8000_0000);
    check("div min/-1 hi", bus.hi, 32'h0);
    run_op(1'b1, 32'd5, 32'd2, -1, -1);
    run_op(1'b1, 32'd5, 32'd0, -1, -1);
    check("div 5/0 hi kept", bus.hi, 32'd1);
    check("div 5/0 lo kept", bus.lo, 32'd2);
    idle_cycles(2);

    // second start mid-flight is dropped; the next one lands right after done
    run_op(1'b0, 32'd2, 32'd4, 10, -1);
    check("mul repulse lo", bus.lo, 32'd8);
    run_op(1'b0, 32'd3, 32'd7, -1, -1);
    check("mul b2b lo", bus.lo, 32'd21);

    run_op(1'b0, 32'd2, 32'd4, -1, 15);
    idle_cycles(1);
    run_op(1'b0, 32'd3, 32'd3, -1, -1);
    check("mul 3x3 after reset lo", bus.lo, 32'd9);

    for (int i = 0; i < 24; i++) begin
      rop = 1'($urandom_range(0, 1));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(rop, ra, rb, -1, -1);
      idle_cycles($urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative signed multiply/divide unit that produces the `hi`/`lo` result pair for the CPU's HI/LO registers. Its outputs feed the multiply/divide result selector: `lo`/`hi` drive the `mult` and `div` inputs, and `op` mirrors `MDControl`. One operation runs at a time over WIDTH+1 cycles under a start/busy/done handshake. Division by zero is flagged to the control unit for exception handling.

## Interface
- `WIDTH`, default 32, operand and result width. Must be even and ≥ 4.
- `clk` input 1, rising-edge clock.
- `reset_n` input 1, asynchronous active-low reset.
- `start` input 1, request pulse. Sampled only in IDLE.
- `op` input 1, operation select: 0 = signed mult, 1 = signed div. Same encoding as `MDControl`.
- `a` input WIDTH, multiplicand or dividend. Sampled with `start`.
- `b` input WIDTH, multiplier or divisor. Sampled with `start`.
- `hi` output WIDTH, product upper half or remainder.
- `lo` output WIDTH, product lower half or quotient.
- `busy` output 1, high while an operation is in flight.
- `done` output 1, one-cycle pulse when a result is committed.
- `div_zero` output 1, one-cycle pulse coincident with `done` when `op`=1 and `b`=0.

## Operation
- FSM states:
  - IDLE: on `start`, latch `op`, `a`, `b`; clear the iteration counter; go to RUN.
  - RUN: one iteration per cycle for exactly WIDTH cycles; go to FIN.
  - FIN: apply sign fix; commit `hi`/`lo`; pulse `done`; go to IDLE.
- Mult:
  - Radix-2 Booth over a 2·WIDTH+1 accumulator.
  - Result is the full 2·WIDTH signed product: `hi` = upper half, `lo` = lower half.
- Div:
  - Restoring division on operand magnitudes.
  - Quotient is negated iff operand signs differ. Remainder takes the dividend's sign (truncation toward zero).
  - `lo` = quotient, `hi` = remainder.
- Most-negative dividend / −1: `lo` = 0x80000000, `hi` = 0 (wraps, no flag).
- Divide by zero:
  - Fixed latency is kept (still runs RUN).
  - In FIN, `hi`/`lo` are not updated; `done` and `div_zero` pulse together.
- `hi`/`lo` hold their last committed value until the next FIN.
- `start` while `busy`: ignored, no queuing. A new `start` is accepted in the cycle after `done` (IDLE).
- `a`/`b`/`op` changes after the sampling edge have no effect.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0, state IDLE.
- `reset_n` low mid-operation aborts immediately. Nothing is committed and the reset values apply.
- Counting the `start`-sampling edge as edge 0:
  - `busy` is high after edges 1..WIDTH+1.
  - `done` (and `div_zero`) is high only between edge WIDTH+1 and WIDTH+2.
  - New `hi`/`lo` are visible from edge WIDTH+1.
- Latency is fixed at WIDTH+1 cycles, independent of operand values. Throughput is one operation per WIDTH+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `mult_div_pkg`:
  - State encoding (IDLE, RUN, FIN).
  - `OP_MULT`=0, `OP_DIV`=1.
  - Counter width `$clog2(WIDTH+1)`.
- Sub-module `div_step`: combinational single restoring-division iteration (shift, trial subtract, quotient bit).
- Booth step, counter, FSM and sign fix live in `mult_div_unit`.

## Test plan
- Mult 2×4 (`op`=0, `a`=2, `b`=4) -> `hi`=0, `lo`=8; `done` only in cycle 33 after the sampling edge; `busy` high cycles 1–33.
- Mult −3×5 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. Mult 0x80000000×0x80000000 -> `hi`=0x40000000, `lo`=0.
- Div −7÷2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Div 4÷2 -> `lo`=2, `hi`=0. Div 0x80000000÷0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- Div 5÷0 after a prior result (`hi`=1, `lo`=2) -> `div_zero` and `done` pulse together at cycle 33; `hi`=1, `lo`=2 unchanged.
- Mult 2×4 with `start` re-pulsed at cycle 10 (`a`=9, `b`=9) -> second request ignored; result `lo`=8; back-to-back `start` at cycle 34 is accepted.
- Mult 2×4 with `reset_n` low at cycle 15 -> `busy`/`done`/`hi`/`lo` = 0 immediately, no `done` pulse; after release, mult 3×3 -> `lo`=9 at latency 33.
